alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational alu between two requesters (e.g. integer pipe and CSR/debug unit).
//  It accepts one operation at a time with round-robin fairness and drives registered operands and opcode to the alu.
//  It captures alu.result and returns it to the owning requester over a valid/ready response channel.
//  It sits beside the alu instance; alu.d1/d2/control come from this block and alu.result feeds back.
// PARAMETERS
//  WIDTH  32  operand/result width; must match alu d1/d2/result
//  OPW    4   opcode width; must match alu control
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      synchronous active-high reset
//  req0_valid   in   1      requester 0 has an operation
//  req0_ready   out  1      requester 0 operation accepted this cycle
//  req0_op      in   OPW    requester 0 alu control code
//  req0_a       in   WIDTH  requester 0 operand d1
//  req0_b       in   WIDTH  requester 0 operand d2
//  req1_valid, req1_ready, req1_op, req1_a, req1_b   same as above, requester 1
//  rsp0_valid   out  1      result for requester 0 is available
//  rsp0_ready   in   1      requester 0 takes the result
//  rsp0_data    out  WIDTH  result for requester 0
//  rsp1_valid, rsp1_ready, rsp1_data                 same as above, requester 1
//  alu_d1       out  WIDTH  to alu.d1, registered
//  alu_d2       out  WIDTH  to alu.d2, registered
//  alu_control  out  OPW    to alu.control, registered
//  alu_result   in   WIDTH  from alu.result
// BEHAVIOUR
//  Reset values: FSM=IDLE; last_grant=1, so req0 wins the first contest.
//   All req*_ready=0, all rsp*_valid=0, rsp*_data=0, alu_d1=0, alu_d2=0, alu_control=0.
//  FSM states: IDLE -> EXEC -> RESP -> IDLE.
//  IDLE:
//   - Grant: if only one reqN_valid, grant N. If both, grant the requester != last_grant.
//   - reqN_ready=1 combinationally for the granted N only, and only in IDLE.
//   - On the accept cycle: latch op/a/b into alu_control/alu_d1/alu_d2, record owner=N, set last_grant=N, go to EXEC.
//  EXEC (one cycle): the alu settles on the registered operands.
//   - At the clock edge: rsp_data_reg<=alu_result, go to RESP.
//  RESP:
//   - rspN_valid=1 for the owner only; rspN_data=captured result, stable while valid.
//   - Owner's rsp_ready=1 -> clear valid, go to IDLE. No new accept in the same cycle.
//   - The other requester's rsp_ready is ignored.
//  Latency: accept at edge T; rsp_valid high from T+2.
//   Minimum issue interval 3 cycles (accept, exec, resp with ready=1).
//  Stall/hold rules:
//   - reqN_valid held with ready=0 is legal; the operation is not consumed.
//   - alu_d1/alu_d2/alu_control hold their last value outside EXEC.
//  The opcode is passed through opaquely; no decoding, no width change. Result width = WIDTH.
//  Boundary cases:
//   - Both requesters valid every cycle -> strict alternation 0,1,0,1...
//   - Requester drops valid before ready -> no grant, no state change.
//   - rst in any state -> immediate return to reset values; an in-flight result is discarded.
//   - rsp_ready held high continuously -> RESP lasts exactly one cycle.
// CONFIGURATION
//  ALU_ARB_STATS_EN defined:
//   - Adds outputs grant_cnt0[15:0] and grant_cnt1[15:0].
//   - Each increments on its requester's accept and saturates at 16'hFFFF.
//   - Both reset to 0 on rst.
//  ALU_ARB_STATS_EN undefined:
//   - Ports and counters are absent; behaviour is otherwise identical.
// TESTING  (bench alu stub: result = d1 ^ d2 ^ {{WIDTH-OPW{1'b0}},control})
//  T1 reset:
//   - rst high 2 cycles with both reqs valid -> all ready/valid 0, alu_* = 0 throughout.
//  T2 single op:
//   - req0 a=32'hF31474A1, b=32'h0000FFFF, op=4'b0011 at T -> req0_ready=1 at T.
//   - rsp0_valid=1 at T+2, rsp0_data=32'hF3148B5D, rsp1_valid=0.
//  T3 contention:
//   - Both valid from reset with rsp ready=1 -> grant order 0,1,0,1.
//   - Each rsp goes to the correct port with that port's data.
//  T4 backpressure:
//   - rsp1_ready=0 for 5 cycles -> rsp1_valid and rsp1_data stable, req0_ready=0 meanwhile.
//   - Release -> req0 is accepted in the next IDLE cycle.
//  T5 mid-op reset:
//   - Assert rst in EXEC -> next cycle IDLE, no rsp_valid.
//   - A fresh req1 afterwards completes normally.
//  T6 (ALU_ARB_STATS_EN):
//   - 3 req0 plus 2 req1 completions -> grant_cnt0=3, grant_cnt1=2.
//   - Force cnt0=16'hFFFF, one more grant -> stays 16'hFFFF.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational alu between two requesters.
// Optional grant statistics are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic [WIDTH-1:0] alu_d1,
  output logic [WIDTH-1:0] alu_d2,
  output logic [OPW-1:0]   alu_control,
  input  logic [WIDTH-1:0] alu_result
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               owner_q, owner_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [WIDTH-1:0]   d1_q, d1_d;
  logic [WIDTH-1:0]   d2_q, d2_d;
  logic [OPW-1:0]     ctrl_q, ctrl_d;

  logic               grant_s;
  logic               accept_s;
  logic               rsp_take_s;

`ifdef ALU_ARB_STATS_EN
  logic [15:0]        grant_cnt0_q, grant_cnt0_d;
  logic [15:0]        grant_cnt1_q, grant_cnt1_d;
`endif

  // Grant selection: a lone requester wins, a tie goes to whoever did not win last time.
  always_comb begin
    grant_s    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_q;
    end else begin
      grant_s = req1_valid;
    end
    accept_s   = ~rst && (state_q == IDLE) && (req0_valid || req1_valid);
    rsp_take_s = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);
  end

  assign req0_ready  = accept_s && ~grant_s;
  assign req1_ready  = accept_s && grant_s;
  assign rsp0_valid  = rsp_valid_q && ~owner_q;
  assign rsp1_valid  = rsp_valid_q && owner_q;
  assign rsp0_data   = owner_q ? '0 : rsp_data_q;
  assign rsp1_data   = owner_q ? rsp_data_q : '0;
  assign alu_d1      = d1_q;
  assign alu_d2      = d2_q;
  assign alu_control = ctrl_q;

  // Next-state logic for the accept / execute / respond sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    d1_d         = d1_q;
    d2_d         = d2_q;
    ctrl_d       = ctrl_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          d1_d         = grant_s ? req1_a  : req0_a;
          d2_d         = grant_s ? req1_b  : req0_b;
          ctrl_d       = grant_s ? req1_op : req0_op;
          owner_d      = grant_s;
          last_grant_d = grant_s;
          state_d      = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_result;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_take_s) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

`ifdef ALU_ARB_STATS_EN
  // Saturating per-requester accept counters.
  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    if (req0_ready && (grant_cnt0_q != 16'hFFFF)) begin
      grant_cnt0_d = grant_cnt0_q + 16'd1;
    end else begin
      grant_cnt0_d = grant_cnt0_q;
    end
    if (req1_ready && (grant_cnt1_q != 16'hFFFF)) begin
      grant_cnt1_d = grant_cnt1_q + 16'd1;
    end else begin
      grant_cnt1_d = grant_cnt1_q;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

  // State register; reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      d1_q         <= '0;
      d2_q         <= '0;
      ctrl_q       <= '0;
`ifdef ALU_ARB_STATS_EN
      grant_cnt0_q <= 16'd0;
      grant_cnt1_q <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
      ctrl_q       <= ctrl_d;
`ifdef ALU_ARB_STATS_EN
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with an xor alu stub; stats checks need ALU_ARB_STATS_EN.
module tb_alu_arbiter;

  localparam logic [31:0] A0 = 32'h12345678;
  localparam logic [31:0] B0 = 32'h0F0F0F0F;
  localparam logic [3:0]  P0 = 4'h1;
  localparam logic [31:0] E0 = 32'h1D3B5976;
  localparam logic [31:0] A1 = 32'hAAAA5555;
  localparam logic [31:0] B1 = 32'h00FF00FF;
  localparam logic [3:0]  P1 = 4'h2;
  localparam logic [31:0] E1 = 32'hAA5555A8;
  localparam logic [31:0] A2 = 32'hF31474A1;
  localparam logic [31:0] B2 = 32'h0000FFFF;
  localparam logic [3:0]  P2 = 4'b0011;
  localparam logic [31:0] E2 = 32'hF3148B5D;
  localparam logic [31:0] A3 = 32'hDEADBEEF;
  localparam logic [31:0] B3 = 32'h00000000;
  localparam logic [3:0]  P3 = 4'hF;
  localparam logic [31:0] E3 = 32'hDEADBEE0;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op, alu_control;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data, alu_d1, alu_d2, alu_result;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign alu_result = alu_d1 ^ alu_d2 ^ {{28{1'b0}}, alu_control};

  alu_arbiter #(.WIDTH(32), .OPW(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_d1(alu_d1), .alu_d2(alu_d2), .alu_control(alu_control),
    .alu_result(alu_result)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction by requester n, starting in an IDLE cycle with inputs already driven.
  task automatic run_op(input int n, input logic [31:0] a, input logic [31:0] exp, input bit hold);
    #1;
    check("accept_ready", n[0] ? req1_ready : req0_ready, 32'd1);
    check("accept_other", n[0] ? req0_ready : req1_ready, 32'd0);
    tick();
    if (!hold) begin
      if (n[0]) req1_valid = 1'b0;
      else      req0_valid = 1'b0;
    end
    check("exec_d1", alu_d1, a);
    check("exec_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    check("rsp_valid", n[0] ? rsp1_valid : rsp0_valid, 32'd1);
    check("rsp_other", n[0] ? rsp0_valid : rsp1_valid, 32'd0);
    check("rsp_data", n[0] ? rsp1_data : rsp0_data, exp);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req0_op = P0; req0_a = A0; req0_b = B0;
    req1_valid = 1'b1; req1_op = P1; req1_a = A1; req1_b = B1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // T1: reset with both requesters valid
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_ready0", req0_ready, 32'd0);
      check("rst_ready1", req1_ready, 32'd0);
      check("rst_rsp0_valid", rsp0_valid, 32'd0);
      check("rst_rsp1_valid", rsp1_valid, 32'd0);
      check("rst_rsp0_data", rsp0_data, 32'd0);
      check("rst_d1", alu_d1, 32'd0);
      check("rst_d2", alu_d2, 32'd0);
      check("rst_ctrl", alu_control, 32'd0);
    end
    rst = 1'b0;

    // T3: contention alternates 0,1,0,1
    run_op(0, A0, E0, 1'b1);
    run_op(1, A1, E1, 1'b1);
    run_op(0, A0, E0, 1'b1);
    run_op(1, A1, E1, 1'b1);

    // T2: single op from requester 0
    req1_valid = 1'b0;
    req0_op = P2; req0_a = A2; req0_b = B2;
    run_op(0, A2, E2, 1'b0);

    // T4: response backpressure on requester 1
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp1_ready = 1'b0;
    #1;
    check("bp_ready1", req1_ready, 32'd1);
    check("bp_ready0", req0_ready, 32'd0);
    tick();
    req1_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp1_valid", rsp1_valid, 32'd1);
      check("bp_rsp1_data", rsp1_data, E1);
      check("bp_ready0_held", req0_ready, 32'd0);
      tick();
    end
    rsp1_ready = 1'b1;
    #1;
    check("bp_release_valid", rsp1_valid, 32'd1);
    tick();
    run_op(0, A2, E2, 1'b0);

    // T5: reset while executing
    req1_op = P3; req1_a = A3; req1_b = B3;
    req1_valid = 1'b1;
    #1;
    check("mr_ready1", req1_ready, 32'd1);
    tick();
    check("mr_exec_d1", alu_d1, A3);
    rst = 1'b1;
    req1_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("mr_rsp1_valid", rsp1_valid, 32'd0);
    check("mr_d1", alu_d1, 32'd0);
    tick();
    check("mr_rsp1_valid_later", rsp1_valid, 32'd0);
    check("mr_rsp0_valid_later", rsp0_valid, 32'd0);
    req1_valid = 1'b1;
    run_op(1, A3, E3, 1'b0);

`ifdef ALU_ARB_STATS_EN
    // T6: grant counters and saturation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1'b1;
      run_op(0, A2, E2, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      req1_valid = 1'b1;
      run_op(1, A3, E3, 1'b0);
    end
    check("cnt0", {16'd0, grant_cnt0}, 32'd3);
    check("cnt1", {16'd0, grant_cnt1}, 32'd2);
    force dut.grant_cnt0_q = 16'hFFFF;
    tick();
    release dut.grant_cnt0_q;
    req0_valid = 1'b1;
    run_op(0, A2, E2, 1'b0);
    check("cnt0_sat", {16'd0, grant_cnt0}, 32'h0000FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
